// File: rtl/game_round_sequencer.sv
// game_round_sequencer: master game FSM and initiator of the score-board handshake.
// Sequences turns, win/draw check, score update, board refresh and game-over.
// Optional feature: define UPD_TIMEOUT_EN to bound the wait for update_done and
// raise the sticky upd_error flag; undefined, the FSM waits indefinitely.
//
// state      | meaning
// S_START    | idle before a game, board held clear, waiting for start edge
// S_PLAYER   | waiting for the human player's move
// S_CPU      | waiting for the CPU engine's move
// S_CHECKING | move settling, round result computed and held
// S_UPDATING | round over, waiting for the score board to settle
// S_REFRESH  | one cycle board clear, first mover swaps
// S_OVER     | a side reached 3, waiting for start edge
module game_round_sequencer #(
    parameter int CHECK_CYCLES = 2,
    parameter int UPD_MASK     = 2,
    parameter int UPD_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       sym_sel,
    input  logic       player_move,
    input  logic       cpu_move,
    input  logic       board_win,
    input  logic       win_symbol,
    input  logic       board_full,
    input  logic       update_done,
    input  logic       gameover,
    output logic [2:0] state,
    output logic [5:0] winning,
    output logic       player_symbol,
    output logic       board_clear,
    output logic       player_turn,
    output logic       upd_error
);

    typedef enum logic [2:0] {
        S_START    = 3'b000,
        S_PLAYER   = 3'b001,
        S_CPU      = 3'b010,
        S_CHECKING = 3'b011,
        S_REFRESH  = 3'b100,
        S_UPDATING = 3'b101,
        S_OVER     = 3'b110
    } state_t;

    // With the timeout the counter must reach UPD_TIMEOUT; without it, it only
    // needs to get past the mask window (the mask never usefully exceeds the timeout).
`ifdef UPD_TIMEOUT_EN
    localparam logic [7:0] UPD_CNT_MAX = 8'hff;
`else
    localparam logic [7:0] UPD_CNT_MAX = 8'((UPD_MASK < UPD_TIMEOUT) ? UPD_MASK : UPD_TIMEOUT);
`endif

    state_t     state_q, state_d;
    logic       start_prev_q;
    logic       start_edge;
    logic [7:0] chk_cnt_q, chk_cnt_d;
    logic [7:0] upd_cnt_q, upd_cnt_d;
    logic [5:0] winning_q, winning_d;
    logic [5:0] round_result;
    logic       player_symbol_q, player_symbol_d;
    logic       board_clear_q, board_clear_d;
    logic       player_turn_q, player_turn_d;
    logic       first_mover_q, first_mover_d;
    logic       upd_error_q, upd_error_d;

    assign start_edge = start_btn & ~start_prev_q;

    // Round outcome from the win checker; a win outranks a full board.
    always_comb begin
        round_result = 6'b000000;
        if (board_win) begin
            round_result = {1'b1, 1'b1, win_symbol, 3'b000};
        end else if (board_full) begin
            round_result = 6'b100000;
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d         = state_q;
        chk_cnt_d       = chk_cnt_q;
        upd_cnt_d       = upd_cnt_q;
        winning_d       = winning_q;
        player_symbol_d = player_symbol_q;
        player_turn_d   = player_turn_q;
        first_mover_d   = first_mover_q;
        upd_error_d     = upd_error_q;
        case (state_q)
            S_START: begin
                upd_error_d = 1'b0;
                if (start_edge) begin
                    player_symbol_d = sym_sel;
                    first_mover_d   = 1'b1;
                    player_turn_d   = 1'b1;
                    state_d         = S_PLAYER;
                end
            end
            S_PLAYER: begin
                if (player_move) begin
                    player_turn_d = ~player_turn_q;
                    chk_cnt_d     = 8'(CHECK_CYCLES - 1);
                    winning_d     = round_result;
                    state_d       = S_CHECKING;
                end
            end
            S_CPU: begin
                if (cpu_move) begin
                    player_turn_d = ~player_turn_q;
                    chk_cnt_d     = 8'(CHECK_CYCLES - 1);
                    winning_d     = round_result;
                    state_d       = S_CHECKING;
                end
            end
            S_CHECKING: begin
                if (chk_cnt_q == 8'd0) begin
                    upd_cnt_d = 8'd0;
                    if (winning_q[5]) begin
                        state_d = S_UPDATING;
                    end else begin
                        state_d = player_turn_q ? S_PLAYER : S_CPU;
                    end
                end else begin
                    chk_cnt_d = chk_cnt_q - 8'd1;
                end
            end
            S_UPDATING: begin
                if (upd_cnt_q != UPD_CNT_MAX) begin
                    upd_cnt_d = upd_cnt_q + 8'd1;
                end
                if ((upd_cnt_q >= 8'(UPD_MASK)) && update_done) begin
                    winning_d = 6'b000000;
                    state_d   = gameover ? S_OVER : S_REFRESH;
                end
`ifdef UPD_TIMEOUT_EN
                else if (upd_cnt_q >= 8'(UPD_TIMEOUT - 1)) begin
                    upd_error_d = 1'b1;
                    winning_d   = 6'b000000;
                    state_d     = S_REFRESH;
                end
`endif
            end
            S_REFRESH: begin
                winning_d     = 6'b000000;
                first_mover_d = ~first_mover_q;
                player_turn_d = ~first_mover_q;
                state_d       = first_mover_q ? S_CPU : S_PLAYER;
            end
            S_OVER: begin
                winning_d = 6'b000000;
                if (start_edge) begin
                    state_d = S_START;
                end
            end
            default: state_d = S_START;
        endcase
        board_clear_d = (state_d == S_START) || (state_d == S_REFRESH);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_START;
            start_prev_q    <= 1'b0;
            chk_cnt_q       <= 8'd0;
            upd_cnt_q       <= 8'd0;
            winning_q       <= 6'b000000;
            player_symbol_q <= 1'b0;
            board_clear_q   <= 1'b0;
            player_turn_q   <= 1'b1;
            first_mover_q   <= 1'b0;
            upd_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_prev_q    <= start_btn;
            chk_cnt_q       <= chk_cnt_d;
            upd_cnt_q       <= upd_cnt_d;
            winning_q       <= winning_d;
            player_symbol_q <= player_symbol_d;
            board_clear_q   <= board_clear_d;
            player_turn_q   <= player_turn_d;
            first_mover_q   <= first_mover_d;
            upd_error_q     <= upd_error_d;
        end
    end

    assign state         = state_q;
    assign winning       = winning_q;
    assign player_symbol = player_symbol_q;
    assign board_clear   = board_clear_q;
    assign player_turn   = player_turn_q;
    assign upd_error     = upd_error_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Randomized bench for game_round_sequencer against a round-level game model.
module tb_game_round_sequencer;

    localparam int C_START = 0, C_PLAYER = 1, C_CPU = 2, C_CHECK = 3,
                   C_REFRESH = 4, C_UPD = 5, C_OVER = 6;
    localparam int MASK = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_btn, sym_sel, player_move, cpu_move;
    logic       board_win, win_symbol, board_full, update_done, gameover;
    logic [2:0] state;
    logic [5:0] winning;
    logic       player_symbol, board_clear, player_turn, upd_error;

    int total = 0;
    int bad   = 0;

    // game model: whose turn, who opened the round, the human's symbol
    bit m_turn, m_first, m_sym;

    game_round_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .sym_sel(sym_sel),
        .player_move(player_move), .cpu_move(cpu_move), .board_win(board_win),
        .win_symbol(win_symbol), .board_full(board_full), .update_done(update_done),
        .gameover(gameover), .state(state), .winning(winning),
        .player_symbol(player_symbol), .board_clear(board_clear),
        .player_turn(player_turn), .upd_error(upd_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [5:0] ref_winning(bit win, bit sym, bit full);
        if (win) return {1'b1, 1'b1, sym, 3'b000};
        if (full) return 6'b100000;
        return 6'b000000;
    endfunction

    function automatic logic [2:0] turn_code(bit t);
        return t ? 3'(C_PLAYER) : 3'(C_CPU);
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state, C_START);
        check({tag, "_winning"}, winning, 0);
        check({tag, "_sym"}, player_symbol, 0);
        check({tag, "_clear"}, board_clear, 0);
        check({tag, "_turn"}, player_turn, 1);
        check({tag, "_err"}, upd_error, 0);
    endtask

    task automatic start_game(input bit sym);
        start_btn = 1'b0;
        tick();
        check("start_idle", state, C_START);
        check("start_clear", board_clear, 1);
        sym_sel   = sym;
        start_btn = 1'b1;
        tick();
        sym_sel = ~sym;
        m_sym = sym; m_first = 1'b1; m_turn = 1'b1;
        check("start_state", state, C_PLAYER);
        check("start_sym", player_symbol, m_sym);
        check("start_turn", player_turn, 1);
        check("start_noclear", board_clear, 0);
        tick();
        check("sym_latched", player_symbol, m_sym);
        start_btn = 1'b0;
    endtask

    task automatic after_refresh();
        check("refresh_state", state, C_REFRESH);
        check("refresh_clear", board_clear, 1);
        check("refresh_winning", winning, 0);
        m_first = ~m_first;
        m_turn  = m_first;
        tick();
        check("post_refresh_state", state, turn_code(m_turn));
        check("post_refresh_turn", player_turn, m_turn);
        check("post_refresh_clear", board_clear, 0);
    endtask

    task automatic commit_move();
        if (m_turn) player_move = 1'b1;
        else        cpu_move    = 1'b1;
        tick();
        player_move = 1'b0;
        cpu_move    = 1'b0;
        m_turn = ~m_turn;
    endtask

    // One move: idle with ignored stimulus, commit, check, optionally score update.
    task automatic play_move(output bit over);
        int idle, outcome, d, exit_k;
        bit gov;
        logic [5:0] expw;
        over = 1'b0;
        idle = $urandom_range(0, 3);
        repeat (idle) begin
            check("wait_state", state, turn_code(m_turn));
            check("wait_turn", player_turn, m_turn);
            if (m_turn) cpu_move    = 1'($urandom_range(0, 1));
            else        player_move = 1'($urandom_range(0, 1));
            start_btn = 1'($urandom_range(0, 1));
            tick();
            player_move = 1'b0;
            cpu_move    = 1'b0;
        end
        check("pre_move_state", state, turn_code(m_turn));
        start_btn = 1'b0;
        outcome = $urandom_range(0, 7);
        board_win  = (outcome == 1) || (outcome == 3);
        board_full = (outcome == 2) || (outcome == 3);
        win_symbol = 1'($urandom_range(0, 1));
        expw = ref_winning(board_win, win_symbol, board_full);
        commit_move();
        check("chk1_state", state, C_CHECK);
        check("chk1_winning", winning, expw);
        check("chk1_turn", player_turn, m_turn);
        check("chk1_clear", board_clear, 0);
        board_win  = 1'($urandom_range(0, 1));
        board_full = 1'($urandom_range(0, 1));
        tick();
        check("chk2_state", state, C_CHECK);
        check("chk2_winning", winning, expw);
        tick();
        if (!expw[5]) begin
            check("next_turn_state", state, turn_code(m_turn));
            return;
        end
        d      = $urandom_range(0, 6);
        gov    = ($urandom_range(0, 3) == 0);
        exit_k = (d > MASK) ? d : MASK;
        for (int k = 0; k <= exit_k; k++) begin
            check("upd_state", state, C_UPD);
            check("upd_winning", winning, expw);
            update_done = (k >= d);
            gameover    = (k >= d) ? gov : 1'($urandom_range(0, 1));
            tick();
        end
        update_done = 1'b0;
        gameover    = 1'b0;
        if (gov) begin
            over = 1'b1;
            check("over_state", state, C_OVER);
            check("over_winning", winning, 0);
            check("over_clear", board_clear, 0);
        end else begin
            after_refresh();
        end
    endtask

    task automatic force_win_move();
        check("fw_state", state, turn_code(m_turn));
        board_win = 1'b1; win_symbol = 1'b1; board_full = 1'b1;
        commit_move();
        tick();
        tick();
        check("fw_upd_state", state, C_UPD);
        check("fw_winning", winning, 6'b111000);
    endtask

    initial begin
        bit over;
        int n;
        rst_n = 1'b0;
        start_btn = 0; sym_sel = 0; player_move = 0; cpu_move = 0;
        board_win = 0; win_symbol = 0; board_full = 0; update_done = 0; gameover = 0;
        #12;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;
        start_game(1'b1);

        for (int r = 0; r < 60; r++) begin
            play_move(over);
            if (over) begin
                start_btn = 1'b0;
                tick();
                check("over_hold", state, C_OVER);
                start_btn = 1'b1;
                tick();
                check("restart_state", state, C_START);
                check("restart_clear", board_clear, 1);
                check("restart_winning", winning, 0);
                tick();
                check("restart_err", upd_error, 0);
                start_game(1'($urandom_range(0, 1)));
            end
        end

        force_win_move();
`ifdef UPD_TIMEOUT_EN
        n = 0;
        while (state == 3'(C_UPD) && n < 400) begin
            n++;
            tick();
        end
        check("timeout_cycles", n, 255);
        check("timeout_err", upd_error, 1);
        after_refresh();
        check("err_sticky", upd_error, 1);
`else
        n = 0;
        repeat (1000) tick();
        check("no_timeout_state", state, C_UPD);
        check("no_timeout_err", upd_error, 0);
        check("no_timeout_winning", winning, 6'b111000);
        update_done = 1'b1;
        tick();
        update_done = 1'b0;
        after_refresh();
`endif

        force_win_move();
        update_done = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        update_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_state", state, C_START);
        check("post_rst_clear", board_clear, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
